// File: rtl/cdb_arbiter_if.sv
// Result channels from the functional units into the CDB arbiter, plus the broadcast bus out of it.
// The master modport is the arbiter side; the slave modport is the execution-unit / snooper side.
interface cdb_arbiter_if #(
  parameter int BW_PROCESSOR_DATA = 32,
  parameter int BW_TAG            = 2,
  parameter int NUM_SOURCE        = 3
);
  logic [NUM_SOURCE-1:0]                   i_fu_valid;
  logic [NUM_SOURCE-1:0]                   i_fu_ready;
  logic [NUM_SOURCE*BW_TAG-1:0]            i_fu_tag_flatten;
  logic [NUM_SOURCE*BW_PROCESSOR_DATA-1:0] i_fu_data_flatten;
  logic                                    o_cdb_valid;
  logic [BW_TAG-1:0]                       o_cdb_tag;
  logic signed [BW_PROCESSOR_DATA-1:0]     o_cdb_data;

  modport master (
    input  i_fu_valid, i_fu_tag_flatten, i_fu_data_flatten,
    output i_fu_ready, o_cdb_valid, o_cdb_tag, o_cdb_data
  );

  modport slave (
    output i_fu_valid, i_fu_tag_flatten, i_fu_data_flatten,
    input  i_fu_ready, o_cdb_valid, o_cdb_tag, o_cdb_data
  );
endinterface

// File: rtl/cdb_arbiter.sv
// Round-robin CDB arbiter: one result buffer per source, registered broadcast one edge after capture.
// Ready depends only on buffer state; the CDB itself has no backpressure.
module cdb_arbiter #(
  parameter int BW_PROCESSOR_DATA = 32,
  parameter int BW_TAG            = 2,
  parameter int NUM_SOURCE        = 3
) (
  input logic            clk,
  input logic            rst_n,
  cdb_arbiter_if.master  bus
);
  localparam int PTR_W = $clog2(NUM_SOURCE);

  logic [NUM_SOURCE-1:0]               buf_valid;
  logic [BW_TAG-1:0]                   buf_tag  [NUM_SOURCE];
  logic signed [BW_PROCESSOR_DATA-1:0] buf_data [NUM_SOURCE];

  logic [BW_TAG-1:0]                   fu_tag   [NUM_SOURCE];
  logic signed [BW_PROCESSOR_DATA-1:0] fu_data  [NUM_SOURCE];

  logic [PTR_W-1:0]      ptr;
  logic [PTR_W-1:0]      grant_idx;
  logic [PTR_W-1:0]      ptr_next;
  logic                  grant_any;
  logic [NUM_SOURCE-1:0] grant;
  logic [NUM_SOURCE-1:0] fu_ready;
  logic [NUM_SOURCE-1:0] fu_take;

  logic                                cdb_valid;
  logic [BW_TAG-1:0]                   cdb_tag;
  logic signed [BW_PROCESSOR_DATA-1:0] cdb_data;

  always_comb begin
    for (int k = 0; k < NUM_SOURCE; k++) begin
      fu_tag[k]  = bus.i_fu_tag_flatten[k*BW_TAG +: BW_TAG];
      fu_data[k] = bus.i_fu_data_flatten[k*BW_PROCESSOR_DATA +: BW_PROCESSOR_DATA];
    end
  end

  // Scanning 2*NUM_SOURCE slots from ptr covers the wrap without a modulo on ptr.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    for (int i = 0; i < 2*NUM_SOURCE; i++) begin
      if (!grant_any && i >= int'(ptr) && buf_valid[i % NUM_SOURCE]) begin
        grant_any = 1'b1;
        grant_idx = PTR_W'(i % NUM_SOURCE);
      end
    end
  end

  always_comb begin
    grant = '0;
    if (grant_any) grant[grant_idx] = 1'b1;
  end

  assign ptr_next = (grant_idx == PTR_W'(NUM_SOURCE-1)) ? '0 : grant_idx + 1'b1;
  assign fu_ready = ~buf_valid | grant;

  // Tag-0 results complete the handshake but are never buffered.
  always_comb begin
    for (int k = 0; k < NUM_SOURCE; k++) begin
      fu_take[k] = bus.i_fu_valid[k] && fu_ready[k] && (fu_tag[k] != '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_valid <= '0;
      ptr       <= '0;
      cdb_valid <= 1'b0;
      cdb_tag   <= '0;
      cdb_data  <= '0;
    end else begin
      for (int k = 0; k < NUM_SOURCE; k++) begin
        if (fu_take[k])    buf_valid[k] <= 1'b1;
        else if (grant[k]) buf_valid[k] <= 1'b0;
      end
      cdb_valid <= grant_any;
      if (grant_any) begin
        cdb_tag  <= buf_tag[grant_idx];
        cdb_data <= buf_data[grant_idx];
        ptr      <= ptr_next;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < NUM_SOURCE; k++) begin
      if (fu_take[k]) begin
        buf_tag[k]  <= fu_tag[k];
        buf_data[k] <= fu_data[k];
      end
    end
  end

  assign bus.i_fu_ready  = fu_ready;
  assign bus.o_cdb_valid = cdb_valid;
  assign bus.o_cdb_tag   = cdb_tag;
  assign bus.o_cdb_data  = cdb_data;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed and random checks of cdb_arbiter against a cycle-level reference model of the arbitration rules.
module tb_cdb_arbiter;
  localparam int N  = 3;
  localparam int TW = 2;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  cdb_arbiter_if #(.BW_PROCESSOR_DATA(DW), .BW_TAG(TW), .NUM_SOURCE(N)) bus ();
  cdb_arbiter #(.BW_PROCESSOR_DATA(DW), .BW_TAG(TW), .NUM_SOURCE(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: pending result per source, index of the next source in rotation, broadcast register.
  bit            m_pend  [N];
  logic [TW-1:0] m_ptag  [N];
  logic [DW-1:0] m_pdata [N];
  int            m_rr;
  bit            m_valid;
  logic [TW-1:0] m_tag;
  logic [DW-1:0] m_data;

  logic [N-1:0]  in_valid;
  logic [TW-1:0] in_tag  [N];
  logic [DW-1:0] in_data [N];
  logic [N-1:0]  last_hs;

  logic [TW-1:0] seen_tag  [$];
  logic [DW-1:0] seen_data [$];
  int            base;

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int k = 0; k < N; k++) m_pend[k] = 1'b0;
    m_rr    = 0;
    m_valid = 1'b0;
    m_tag   = '0;
    m_data  = '0;
  endfunction

  function automatic int model_pick();
    for (int d = 0; d < N; d++) begin
      if (m_pend[(m_rr + d) % N]) return (m_rr + d) % N;
    end
    return -1;
  endfunction

  // One cycle: drive inputs at the falling edge, check ready, advance the model at the rising edge,
  // then check the broadcast register at the next falling edge.
  task automatic step();
    int           g;
    logic [N-1:0] exp_rdy;
    for (int k = 0; k < N; k++) begin
      bus.i_fu_valid[k]                 = in_valid[k];
      bus.i_fu_tag_flatten[k*TW +: TW]  = in_tag[k];
      bus.i_fu_data_flatten[k*DW +: DW] = in_data[k];
    end
    g = model_pick();
    for (int k = 0; k < N; k++) exp_rdy[k] = !m_pend[k] || (g == k);
    #1;
    check("i_fu_ready", 64'(bus.i_fu_ready), 64'(exp_rdy));
    last_hs = in_valid & exp_rdy;
    @(posedge clk);
    if (g >= 0) begin
      m_valid   = 1'b1;
      m_tag     = m_ptag[g];
      m_data    = m_pdata[g];
      m_rr      = (g + 1) % N;
      m_pend[g] = 1'b0;
    end else begin
      m_valid = 1'b0;
    end
    for (int k = 0; k < N; k++) begin
      if (last_hs[k] && in_tag[k] != '0) begin
        m_pend[k]  = 1'b1;
        m_ptag[k]  = in_tag[k];
        m_pdata[k] = in_data[k];
      end
    end
    @(negedge clk);
    check("cdb_valid", 64'(bus.o_cdb_valid), 64'(m_valid));
    check("cdb_tag",   64'(bus.o_cdb_tag),   64'(m_tag));
    check("cdb_data",  64'($unsigned(bus.o_cdb_data)), 64'(m_data));
    if (bus.o_cdb_valid) begin
      seen_tag.push_back(bus.o_cdb_tag);
      seen_data.push_back(bus.o_cdb_data);
    end
  endtask

  task automatic pulse_reset(input string name);
    #2 rst_n = 1'b0;
    #1;
    check({name, "_valid"}, 64'(bus.o_cdb_valid), 64'd0);
    check({name, "_tag"},   64'(bus.o_cdb_tag),   64'd0);
    check({name, "_data"},  64'($unsigned(bus.o_cdb_data)), 64'd0);
    model_reset();
    in_valid = '0;
    last_hs  = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = '0;
    last_hs  = '0;
    for (int k = 0; k < N; k++) begin
      in_tag[k]  = '0;
      in_data[k] = '0;
    end
    bus.i_fu_valid        = '0;
    bus.i_fu_tag_flatten  = '0;
    bus.i_fu_data_flatten = '0;
    model_reset();

    #12;
    check("por_valid", 64'(bus.o_cdb_valid), 64'd0);
    check("por_tag",   64'(bus.o_cdb_tag),   64'd0);
    check("por_data",  64'($unsigned(bus.o_cdb_data)), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    check("por_ready", 64'(bus.i_fu_ready), 64'h7);
    repeat (2) step();

    // Lone source 1: broadcast for exactly one cycle, one edge after capture.
    in_valid = 3'b010; in_tag[1] = 2'd2; in_data[1] = 32'h0000_1234;
    step();
    check("single_wait", 64'(bus.o_cdb_valid), 64'd0);
    in_valid = '0;
    step();
    check("single_bcast", {29'd0, bus.o_cdb_valid, bus.o_cdb_tag, $unsigned(bus.o_cdb_data)},
          {29'd0, 1'b1, 2'd2, 32'h0000_1234});
    step();
    check("single_once", 64'(bus.o_cdb_valid), 64'd0);

    // Mid-run reset while a broadcast is showing and another result is buffered.
    in_valid = 3'b011; in_tag[0] = 2'd1; in_data[0] = 32'd5; in_tag[1] = 2'd2; in_data[1] = 32'd6;
    step();
    in_valid = '0;
    step();
    check("pre_rst_valid", 64'(bus.o_cdb_valid), 64'd1);
    pulse_reset("midrst");
    check("midrst_ready", 64'(bus.i_fu_ready), 64'h7);
    repeat (2) step();

    // Contention straight after reset.
    in_valid = 3'b111;
    for (int k = 0; k < N; k++) begin
      in_tag[k]  = TW'(k + 1);
      in_data[k] = DW'(100 * (k + 1));
    end
    base = seen_tag.size();
    step();
    in_valid = '0;
    repeat (4) step();
    check("cont_count", 64'(seen_tag.size() - base), 64'd3);
    for (int i = 0; i < 3; i++) check("cont_order", 64'(seen_tag[base + i]), 64'(i + 1));

    // Tag 0 is accepted and dropped; rotation must start from the same place as before.
    in_valid = 3'b010; in_tag[1] = 2'd0; in_data[1] = 32'h0000_DEAD;
    step();
    check("tag0_hs", 64'(last_hs[1]), 64'd1);
    in_valid = '0;
    step();
    check("tag0_nobcast", 64'(bus.o_cdb_valid), 64'd0);
    step();
    in_valid = 3'b111;
    for (int k = 0; k < N; k++) in_tag[k] = TW'(k + 1);
    base = seen_tag.size();
    step();
    in_valid = '0;
    repeat (4) step();
    for (int i = 0; i < 3; i++) check("tag0_ptr_order", 64'(seen_tag[base + i]), 64'(i + 1));

    // Streaming from source 0.
    base = seen_tag.size();
    for (int i = 0; i < 4; i++) begin
      in_valid   = 3'b001;
      in_tag[0]  = (i == 3) ? 2'd1 : TW'(i + 1);
      in_data[0] = DW'(10 * (i + 1));
      step();
      check("stream_ready", 64'(last_hs[0]), 64'd1);
    end
    in_valid = '0;
    repeat (3) step();
    check("stream_count", 64'(seen_tag.size() - base), 64'd4);
    for (int i = 0; i < 4; i++) begin
      check("stream_tag",  64'(seen_tag[base + i]),  64'((i == 3) ? 1 : i + 1));
      check("stream_data", 64'(seen_data[base + i]), 64'(10 * (i + 1)));
    end

    // Sources 0 and 2 continuously valid: broadcasts must alternate.
    in_valid = 3'b101; in_tag[0] = 2'd1; in_tag[2] = 2'd3;
    base = seen_tag.size();
    for (int i = 0; i < 12; i++) begin
      step();
      for (int k = 0; k < N; k++) if (last_hs[k]) in_data[k] = in_data[k] + 1;
    end
    in_valid = '0;
    repeat (3) step();
    check("fair_count_ok", 64'(seen_tag.size() - base >= 10), 64'd1);
    for (int i = base + 1; i < seen_tag.size(); i++) begin
      check("fair_alternate", 64'(seen_tag[i] != seen_tag[i - 1]), 64'd1);
      check("fair_tagset", 64'(seen_tag[i] == 2'd1 || seen_tag[i] == 2'd3), 64'd1);
    end

    // Random traffic; a source left waiting keeps its item stable until accepted.
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < N; k++) begin
        if (!(in_valid[k] && !last_hs[k])) begin
          in_valid[k] = ($urandom_range(0, 3) != 0);
          in_tag[k]   = TW'($urandom_range(0, 3));
          in_data[k]  = $urandom;
        end
      end
      step();
      if (c == 200) begin
        pulse_reset("rndrst");
        step();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
